// File: rtl/zigzag_pkg.sv
// Shared types and default constants for the rail-fence (zigzag) decryption engine.
package zigzag_pkg;

    typedef enum logic [1:0] {
        RECV = 2'd0,
        CALC = 2'd1,
        EMIT = 2'd2
    } zz_state_t;

    localparam logic [7:0] TERM_TOKEN_DEF = 8'hFA;
    localparam int         MAX_LEN_DEF    = 50;
    localparam int         KEY_MAX_DEF    = 5;

endpackage

// File: rtl/zigzag_addr_gen.sv
// Combinational read-address generator: maps the emit phase/cycle counters
// onto the buffer position of the next plaintext byte.
module zigzag_addr_gen
    import zigzag_pkg::*;
#(
    parameter int KEY_MAX = KEY_MAX_DEF,
    parameter int ADDR_W  = 6,
    parameter int PH_W    = 4,
    parameter int KW      = 3
) (
    input  logic [KW-1:0]                   k,
    input  logic [PH_W-1:0]                 period,
    input  logic [KEY_MAX-1:0][ADDR_W-1:0]  start,
    input  logic [PH_W-1:0]                 phase,
    input  logic [ADDR_W-1:0]               cycle,
    input  logic [ADDR_W-1:0]               idx,
    output logic [ADDR_W-1:0]               addr
);

    logic              descending;
    logic [KW-1:0]     rail;
    logic [ADDR_W-1:0] offset;

    always_comb begin
        descending = (phase >= PH_W'(k));
        rail       = descending ? KW'(period - phase) : KW'(phase);
        // Middle rails are visited twice per period: once going down, once coming up.
        if (rail == '0 || rail == k - KW'(1)) begin
            offset = cycle;
        end else begin
            offset = ADDR_W'({cycle, 1'b0}) + ADDR_W'(descending);
        end
        addr = (k == KW'(1)) ? idx : start[rail] + offset;
    end

endmodule

// File: rtl/zigzag_decryption.sv
// Rail-fence decryption engine: buffers one ciphertext message up to the
// terminator byte, derives rail boundaries, then emits plaintext one byte per cycle.
module zigzag_decryption
    import zigzag_pkg::*;
#(
    parameter int                 D_WIDTH    = 8,
    parameter int                 KEY_WIDTH  = 16,
    parameter int                 MAX_LEN    = MAX_LEN_DEF,
    parameter int                 KEY_MAX    = KEY_MAX_DEF,
    parameter logic [D_WIDTH-1:0] TERM_TOKEN = D_WIDTH'(TERM_TOKEN_DEF)
) (
    input  logic                 clk_sys,
    input  logic                 rst,
    input  logic [D_WIDTH-1:0]   data_i,
    input  logic                 valid_i,
    input  logic [KEY_WIDTH-1:0] key,
    output logic                 busy,
    output logic [D_WIDTH-1:0]   data_o,
    output logic                 valid_o
);

    localparam int ADDR_W = $clog2(MAX_LEN + 1);
    localparam int PH_W   = $clog2(2 * KEY_MAX + 1);
    localparam int KW     = $clog2(KEY_MAX + 1);

    function automatic logic [KW-1:0] clip_key(input logic [7:0] raw);
        logic [KW-1:0] k;
        if (raw == 8'd0) begin
            k = KW'(1);
        end else if (raw > 8'(KEY_MAX)) begin
            k = KW'(KEY_MAX);
        end else begin
            k = KW'(raw);
        end
        return k;
    endfunction

    function automatic logic [PH_W-1:0] period_of(input logic [KW-1:0] k);
        return PH_W'(k - KW'(1)) << 1;
    endfunction

    zz_state_t state, state_nxt;

    logic [D_WIDTH-1:0]              mem [MAX_LEN];
    logic [ADDR_W-1:0]               n_cnt;
    logic [PH_W-1:0]                 phase;
    logic [ADDR_W-1:0]               cyc;
    logic [KW-1:0]                   k_lat;
    logic [KW-1:0]                   calc_r;
    logic [ADDR_W-1:0]               acc;
    logic [KEY_MAX-1:0][ADDR_W-1:0]  start;
    logic [ADDR_W-1:0]               idx;
    logic [PH_W-1:0]                 emit_p;
    logic [ADDR_W-1:0]               emit_c;

    logic [KW-1:0]     k_cur;
    logic [PH_W-1:0]   p_cur;
    logic [PH_W-1:0]   p_lat;
    logic              term_hit;
    logic              byte_hit;
    logic              calc_last;
    logic              emit_done;
    logic              emit_fire;
    logic              gt_r, gt_k, gt_pr;
    logic [ADDR_W-1:0] rail_len;
    logic [ADDR_W-1:0] rd_addr;
    logic              unused_key;

    assign unused_key = ^key[KEY_WIDTH-1:8];
    assign k_cur      = clip_key(key[7:0]);
    assign p_cur      = period_of(k_cur);
    assign p_lat      = period_of(k_lat);
    assign term_hit   = (state == RECV) && valid_i && (data_i == TERM_TOKEN);
    assign byte_hit   = (state == RECV) && valid_i && (data_i != TERM_TOKEN)
                        && (n_cnt != ADDR_W'(MAX_LEN));
    assign calc_last  = (calc_r == k_lat - KW'(1));
    assign emit_done  = (idx == n_cnt);

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state <= RECV;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        emit_fire = 1'b0;
        case (state)
            RECV: if (term_hit) state_nxt = CALC;
            CALC: if (calc_last) state_nxt = (n_cnt == '0) ? RECV : EMIT;
            EMIT: begin
                if (emit_done) state_nxt = RECV;
                else           emit_fire = 1'b1;
            end
            default: state_nxt = RECV;
        endcase
    end

    // Rail length for rail calc_r; phase and cyc hold N mod P and N / P during CALC.
    always_comb begin
        gt_r  = (phase > PH_W'(calc_r));
        gt_k  = (phase > PH_W'(k_lat - KW'(1)));
        gt_pr = (phase > (p_lat - PH_W'(calc_r)));
        if (calc_r == '0) begin
            rail_len = cyc + ADDR_W'(gt_r);
        end else if (calc_last) begin
            rail_len = cyc + ADDR_W'(gt_k);
        end else begin
            rail_len = (cyc << 1) + ADDR_W'(gt_r) + ADDR_W'(gt_pr);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (byte_hit) mem[n_cnt] <= data_i;
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            n_cnt  <= '0;
            phase  <= '0;
            cyc    <= '0;
            k_lat  <= KW'(1);
            calc_r <= '0;
            acc    <= '0;
            start  <= '0;
            idx    <= '0;
            emit_p <= '0;
            emit_c <= '0;
        end else begin
            case (state)
                RECV: begin
                    if (term_hit) begin
                        k_lat  <= k_cur;
                        calc_r <= '0;
                        acc    <= '0;
                        idx    <= '0;
                        emit_p <= '0;
                        emit_c <= '0;
                    end else if (byte_hit) begin
                        n_cnt <= n_cnt + ADDR_W'(1);
                        if (p_cur == '0 || (phase + PH_W'(1)) >= p_cur) begin
                            phase <= '0;
                            cyc   <= cyc + ADDR_W'(1);
                        end else begin
                            phase <= phase + PH_W'(1);
                        end
                    end
                end
                CALC: begin
                    start[calc_r] <= acc;
                    acc           <= acc + rail_len;
                    calc_r        <= calc_r + KW'(1);
                    if (calc_last && n_cnt == '0) begin
                        phase <= '0;
                        cyc   <= '0;
                    end
                end
                EMIT: begin
                    if (emit_done) begin
                        n_cnt <= '0;
                        phase <= '0;
                        cyc   <= '0;
                    end else begin
                        idx <= idx + ADDR_W'(1);
                        if (p_lat == '0 || (emit_p + PH_W'(1)) >= p_lat) begin
                            emit_p <= '0;
                            emit_c <= emit_c + ADDR_W'(1);
                        end else begin
                            emit_p <= emit_p + PH_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    zigzag_addr_gen #(
        .KEY_MAX (KEY_MAX),
        .ADDR_W  (ADDR_W),
        .PH_W    (PH_W),
        .KW      (KW)
    ) u_addr_gen (
        .k      (k_lat),
        .period (p_lat),
        .start  (start),
        .phase  (emit_p),
        .cycle  (emit_c),
        .idx    (idx),
        .addr   (rd_addr)
    );

    // Output register stage
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            busy    <= 1'b0;
            valid_o <= 1'b0;
            data_o  <= '0;
        end else begin
            busy    <= (state_nxt != RECV);
            valid_o <= emit_fire;
            data_o  <= emit_fire ? mem[rd_addr] : '0;
        end
    end

endmodule
